// File: rtl/aw_gate_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aw_gate_pkg
// Description : Shared widths, AW transaction-type codes and the admission
//               gate state encoding for the write-address path.
// Revision    : 1.0 - initial release
// ============================================================================
package aw_gate_pkg;

   localparam int unsigned PID_WIDTH     = 4;
   localparam int unsigned PAWUSER_WIDTH = 2;

   // AW transaction types carried on awuser
   localparam logic [PAWUSER_WIDTH-1:0] REGULAR = 2'b00;
   localparam logic [PAWUSER_WIDTH-1:0] BLOCK   = 2'b01;
   localparam logic [PAWUSER_WIDTH-1:0] DIVERT  = 2'b10;

   typedef enum logic [1:0] {
      OPEN     = 2'd0,
      BLK_WAIT = 2'd1,
      DIV_WAIT = 2'd2,
      DIV_ACK  = 2'd3
   } gate_state_t;

endpackage : aw_gate_pkg
`default_nettype wire

// File: rtl/aw_gate_rise.sv
`default_nettype none
// ============================================================================
// Module      : rise
// Description : Free-running rising-edge detector. Produces a one-cycle
//               combinational pulse in the cycle where sig_in is high and
//               was low on the previous clock edge.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               sig_in - level input to watch
//               pulse  - high while sig_in is 1 and its last sample was 0
// Revision    : 1.0 - initial release
// ============================================================================
module rise (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic pulse
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = sig_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign pulse = sig_in & ~prev_q;

endmodule : rise
`default_nettype wire

// File: rtl/aw_gate.sv
`default_nettype none
// ============================================================================
// Module      : aw_gate
// Description : Write-address admission stage in front of process_mem.
//               Holds one master AW request and releases it downstream only
//               when the tracker has room and no BLOCK/DIVERT ordering
//               hazard is outstanding.
// Ports       : clk, rst_n             - clock, async active-low reset
//               s_awid/s_awuser/s_awvalid/s_awready - master AW channel
//               m_awid/m_awuser/m_awvalid/m_awready - downstream AW channel
//               trk_full, trk_empty    - tracker occupancy
//               block_fin              - BLOCK transaction completed
//               spec_release           - DIVERT transaction released
//               release_ready          - one-cycle ack of spec_release
//               gate_busy              - gate is in a wait/ack state
//               err_timeout            - sticky wait-state timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module aw_gate
   import aw_gate_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PID_WIDTH-1:0]     s_awid,
   input  logic [PAWUSER_WIDTH-1:0] s_awuser,
   input  logic                     s_awvalid,
   output logic                     s_awready,
   output logic [PID_WIDTH-1:0]     m_awid,
   output logic [PAWUSER_WIDTH-1:0] m_awuser,
   output logic                     m_awvalid,
   input  logic                     m_awready,
   input  logic                     trk_full,
   input  logic                     trk_empty,
   input  logic                     block_fin,
   input  logic                     spec_release,
   output logic                     release_ready,
   output logic                     gate_busy,
   output logic                     err_timeout
);

   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   gate_state_t                state_q,     state_d;
   logic                       live_q,      live_d;
   logic                       hold_v_q,    hold_v_d;
   logic [PID_WIDTH-1:0]       hold_id_q,   hold_id_d;
   logic [PAWUSER_WIDTH-1:0]   hold_type_q, hold_type_d;
   logic                       m_awvalid_q, m_awvalid_d;
   logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;
   logic                       err_q,       err_d;
   logic                       blk_pend_q,  blk_pend_d;
   logic                       div_pend_q,  div_pend_d;

   logic                       fin_rise;
   logic                       rel_rise;
   logic                       s_hs;
   logic                       m_hs;
   logic                       issue_ok;

   rise u_fin_rise (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (block_fin),
      .pulse  (fin_rise)
   );

   rise u_rel_rise (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (spec_release),
      .pulse  (rel_rise)
   );

   // live_q keeps s_awready low until the first edge after reset release
   assign s_awready     = live_q & ~hold_v_q;
   assign m_awvalid     = m_awvalid_q;
   assign m_awid        = hold_id_q;
   assign m_awuser      = hold_type_q;
   assign release_ready = (state_q == DIV_ACK);
   assign gate_busy     = (state_q != OPEN);
   assign err_timeout   = err_q;

   assign s_hs = s_awvalid & s_awready;
   assign m_hs = m_awvalid_q & m_awready;

   // A DIVERT may only enter an empty tracker; everything else needs room
   always_comb begin
      issue_ok = 1'b0;
      if (state_q == OPEN) begin
         if (hold_type_q == DIVERT) begin
            issue_ok = trk_empty;
         end else begin
            issue_ok = ~trk_full;
         end
      end
   end

   always_comb begin
      live_d      = 1'b1;
      hold_v_d    = hold_v_q;
      hold_id_d   = hold_id_q;
      hold_type_d = hold_type_q;
      m_awvalid_d = m_awvalid_q;
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      err_d       = err_q;
      blk_pend_d  = blk_pend_q;
      div_pend_d  = div_pend_q;

      // s accept needs an empty entry, m issue needs a full one, so the two
      // never coincide
      if (s_hs) begin
         hold_v_d    = 1'b1;
         hold_id_d   = s_awid;
         hold_type_d = s_awuser;
      end
      if (m_hs) begin
         hold_v_d = 1'b0;
      end

      // Once raised, valid is held until accepted regardless of issue_ok.
      // After acceptance hold_v_q is already clear on the next cycle, which
      // guarantees the low gap process_mem needs for its edge detector.
      if (m_awvalid_q) begin
         m_awvalid_d = ~m_awready;
      end else begin
         m_awvalid_d = hold_v_q & issue_ok;
      end

      case (state_q)
         OPEN: begin
            if (m_hs && (hold_type_q == BLOCK)) begin
               state_d     = BLK_WAIT;
               stall_cnt_d = '0;
               // remember a completion edge that lands on the entry cycle
               blk_pend_d  = fin_rise;
            end else if (m_hs && (hold_type_q == DIVERT)) begin
               state_d     = DIV_WAIT;
               stall_cnt_d = '0;
               div_pend_d  = rel_rise;
            end
         end
         BLK_WAIT: begin
            if (fin_rise || blk_pend_q) begin
               state_d    = OPEN;
               blk_pend_d = 1'b0;
            end else if (stall_cnt_q == C_CNT_LAST) begin
               state_d    = OPEN;
               err_d      = 1'b1;
               blk_pend_d = 1'b0;
            end else if (stall_cnt_q != C_CNT_MAX) begin
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
         end
         DIV_WAIT: begin
            if (rel_rise || div_pend_q) begin
               state_d    = DIV_ACK;
               div_pend_d = 1'b0;
            end else if (stall_cnt_q == C_CNT_LAST) begin
               state_d    = OPEN;
               err_d      = 1'b1;
               div_pend_d = 1'b0;
            end else if (stall_cnt_q != C_CNT_MAX) begin
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
         end
         DIV_ACK: begin
            state_d = OPEN;
         end
         default: begin
            state_d = OPEN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= OPEN;
         live_q      <= 1'b0;
         hold_v_q    <= 1'b0;
         hold_id_q   <= '0;
         hold_type_q <= '0;
         m_awvalid_q <= 1'b0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
         blk_pend_q  <= 1'b0;
         div_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         live_q      <= live_d;
         hold_v_q    <= hold_v_d;
         hold_id_q   <= hold_id_d;
         hold_type_q <= hold_type_d;
         m_awvalid_q <= m_awvalid_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
         blk_pend_q  <= blk_pend_d;
         div_pend_q  <= div_pend_d;
      end
   end

endmodule : aw_gate
`default_nettype wire

// File: tb/tb_aw_gate.sv
`default_nettype none
// ============================================================================
// Module      : tb_aw_gate
// Description : Self-checking bench for aw_gate: a table of single AW
//               transactions followed by hand-written multi-cycle sequences
//               for hazards, backpressure, timeout and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aw_gate;
   import aw_gate_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic [PID_WIDTH-1:0]     s_awid;
   logic [PAWUSER_WIDTH-1:0] s_awuser;
   logic                     s_awvalid;
   logic                     s_awready;
   logic [PID_WIDTH-1:0]     m_awid;
   logic [PAWUSER_WIDTH-1:0] m_awuser;
   logic                     m_awvalid;
   logic                     m_awready;
   logic                     trk_full;
   logic                     trk_empty;
   logic                     block_fin;
   logic                     spec_release;
   logic                     release_ready;
   logic                     gate_busy;
   logic                     err_timeout;

   int checks   = 0;
   int failures = 0;

   aw_gate #(.TIMEOUT_CYCLES(1024)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_awid       (s_awid),
      .s_awuser     (s_awuser),
      .s_awvalid    (s_awvalid),
      .s_awready    (s_awready),
      .m_awid       (m_awid),
      .m_awuser     (m_awuser),
      .m_awvalid    (m_awvalid),
      .m_awready    (m_awready),
      .trk_full     (trk_full),
      .trk_empty    (trk_empty),
      .block_fin    (block_fin),
      .spec_release (spec_release),
      .release_ready(release_ready),
      .gate_busy    (gate_busy),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PID_WIDTH-1:0]     id;
      logic [PAWUSER_WIDTH-1:0] typ;
      logic                     exp_busy;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one AW and hold it for exactly one edge; the handshake lands there
   task automatic send(input logic [PID_WIDTH-1:0] id, input logic [PAWUSER_WIDTH-1:0] typ);
      int n;
      n = 0;
      while (!s_awready && n < 50) begin
         tick();
         n++;
      end
      chk("send_ready", 32'(s_awready), 32'd1);
      s_awvalid = 1'b1;
      s_awid    = id;
      s_awuser  = typ;
      tick();
      s_awvalid = 1'b0;
      chk("ready_low_after_accept", 32'(s_awready), 32'd0);
   endtask

   initial begin
      int n;
      int bad;

      vecs[0] = '{id: 4'd3,  typ: REGULAR, exp_busy: 1'b0};
      vecs[1] = '{id: 4'd5,  typ: REGULAR, exp_busy: 1'b0};
      vecs[2] = '{id: 4'd2,  typ: BLOCK,   exp_busy: 1'b1};
      vecs[3] = '{id: 4'd7,  typ: DIVERT,  exp_busy: 1'b1};
      vecs[4] = '{id: 4'd15, typ: REGULAR, exp_busy: 1'b0};
      vecs[5] = '{id: 4'd0,  typ: BLOCK,   exp_busy: 1'b1};

      rst_n        = 1'b0;
      s_awid       = '0;
      s_awuser     = '0;
      s_awvalid    = 1'b0;
      m_awready    = 1'b1;
      trk_full     = 1'b0;
      trk_empty    = 1'b1;
      block_fin    = 1'b0;
      spec_release = 1'b0;

      // ---------------- reset state ----------------
      #2;
      chk("rst_s_awready",     32'(s_awready),     32'd0);
      chk("rst_m_awvalid",     32'(m_awvalid),     32'd0);
      chk("rst_m_awid",        32'(m_awid),        32'd0);
      chk("rst_m_awuser",      32'(m_awuser),      32'd0);
      chk("rst_release_ready", 32'(release_ready), 32'd0);
      chk("rst_gate_busy",     32'(gate_busy),     32'd0);
      chk("rst_err_timeout",   32'(err_timeout),   32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("ready_after_reset", 32'(s_awready), 32'd1);

      // ---------------- table of single transactions ----------------
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].id, vecs[i].typ);
         chk("no_early_valid", 32'(m_awvalid), 32'd0);
         tick();
         chk("tbl_valid", 32'(m_awvalid), 32'd1);
         chk("tbl_id",    32'(m_awid),    32'(vecs[i].id));
         chk("tbl_user",  32'(m_awuser),  32'(vecs[i].typ));
         tick();
         chk("tbl_gap",   32'(m_awvalid), 32'd0);
         chk("tbl_busy",  32'(gate_busy), 32'(vecs[i].exp_busy));
         if (vecs[i].typ == BLOCK) begin
            block_fin = 1'b1;
            tick();
            block_fin = 1'b0;
            chk("tbl_blk_open", 32'(gate_busy), 32'd0);
         end else if (vecs[i].typ == DIVERT) begin
            spec_release = 1'b1;
            tick();
            spec_release = 1'b0;
            chk("tbl_rr_high", 32'(release_ready), 32'd1);
            tick();
            chk("tbl_rr_low",  32'(release_ready), 32'd0);
            chk("tbl_div_open", 32'(gate_busy), 32'd0);
         end
      end

      // ---------------- BLOCK then REGULAR held until block_fin ----------------
      send(4'd2, BLOCK);
      tick();
      chk("blk_valid", 32'(m_awvalid), 32'd1);
      tick();
      chk("blk_busy", 32'(gate_busy), 32'd1);
      send(4'd4, REGULAR);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (m_awvalid !== 1'b0) bad++;
         tick();
      end
      chk("blk_held_cycles", 32'(bad), 32'd0);
      block_fin = 1'b1;
      tick();
      block_fin = 1'b0;
      chk("blk_open_after_fin", 32'(gate_busy), 32'd0);
      chk("blk_not_yet_valid",  32'(m_awvalid), 32'd0);
      tick();
      chk("blk_held_issued", 32'(m_awvalid), 32'd1);
      chk("blk_held_id",     32'(m_awid),    32'd4);
      tick();
      chk("blk_held_gap",    32'(m_awvalid), 32'd0);

      // ---------------- DIVERT waits for empty tracker ----------------
      trk_empty = 1'b0;
      send(4'd7, DIVERT);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         if (m_awvalid !== 1'b0) bad++;
         tick();
      end
      chk("div_not_issued", 32'(bad), 32'd0);
      trk_empty = 1'b1;
      tick();
      chk("div_issued",   32'(m_awvalid), 32'd1);
      chk("div_id",       32'(m_awid),    32'd7);
      chk("div_user",     32'(m_awuser),  32'(DIVERT));
      tick();
      chk("div_busy",     32'(gate_busy), 32'd1);
      chk("div_rr_idle",  32'(release_ready), 32'd0);
      spec_release = 1'b1;
      tick();
      spec_release = 1'b0;
      chk("div_rr_pulse", 32'(release_ready), 32'd1);
      tick();
      chk("div_rr_drop",  32'(release_ready), 32'd0);
      chk("div_open",     32'(gate_busy),     32'd0);

      // ---------------- trk_full backpressure and AXI stability ----------------
      trk_full  = 1'b1;
      m_awready = 1'b0;
      send(4'd9, REGULAR);
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         if (m_awvalid !== 1'b0) bad++;
         tick();
      end
      chk("full_blocks_issue", 32'(bad), 32'd0);
      trk_full = 1'b0;
      tick();
      chk("full_cleared_issue", 32'(m_awvalid), 32'd1);
      trk_full = 1'b1;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (m_awvalid !== 1'b1 || m_awid !== 4'd9) bad++;
      end
      chk("valid_stable_under_full", 32'(bad), 32'd0);
      m_awready = 1'b1;
      tick();
      chk("valid_drop_on_ready", 32'(m_awvalid), 32'd0);
      trk_full = 1'b0;

      // ---------------- block_fin edge on the BLK_WAIT entry cycle ----------------
      send(4'd11, BLOCK);
      tick();
      chk("sim_valid", 32'(m_awvalid), 32'd1);
      block_fin = 1'b1;
      tick();
      block_fin = 1'b0;
      chk("sim_busy_entry", 32'(gate_busy), 32'd1);
      tick();
      chk("sim_edge_kept", 32'(gate_busy), 32'd0);

      // ---------------- timeout in BLK_WAIT ----------------
      send(4'd1, BLOCK);
      tick();
      tick();
      chk("to_busy", 32'(gate_busy), 32'd1);
      send(4'd6, REGULAR);
      n   = 1;
      bad = 0;
      while (gate_busy && n < 1100) begin
         if (m_awvalid !== 1'b0) bad++;
         tick();
         n++;
      end
      chk("to_cycles",     32'(n),           32'd1024);
      chk("to_no_issue",   32'(bad),         32'd0);
      chk("to_err",        32'(err_timeout), 32'd1);
      chk("to_valid_low",  32'(m_awvalid),   32'd0);
      tick();
      chk("to_resume",     32'(m_awvalid),   32'd1);
      chk("to_resume_id",  32'(m_awid),      32'd6);
      tick();
      chk("to_err_sticky", 32'(err_timeout), 32'd1);

      // ---------------- reset in DIV_WAIT with an entry held ----------------
      send(4'd12, DIVERT);
      tick();
      tick();
      chk("rd_busy", 32'(gate_busy), 32'd1);
      send(4'd13, REGULAR);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rd_s_awready", 32'(s_awready),     32'd0);
      chk("rd_m_awvalid", 32'(m_awvalid),     32'd0);
      chk("rd_m_awid",    32'(m_awid),        32'd0);
      chk("rd_m_awuser",  32'(m_awuser),      32'd0);
      chk("rd_rr",        32'(release_ready), 32'd0);
      chk("rd_busy_clr",  32'(gate_busy),     32'd0);
      chk("rd_err_clr",   32'(err_timeout),   32'd0);
      tick();
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (m_awvalid !== 1'b0) bad++;
      end
      chk("rd_no_replay",  32'(bad),       32'd0);
      chk("rd_ready_back", 32'(s_awready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_aw_gate
`default_nettype wire
